// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the RV32M divide/remainder sequencer.
//   XLEN   : operand/result width (iteration count)
//   CNT_W  : width of the iteration counter
//   div_op_e    : funct3[1:0] operation encoding
//   div_state_e : sequencer FSM states
package div_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
//   flush              : pipeline flush, aborts any in-flight op
//   in_valid/in_ready  : request handshake; op, rs1 (dividend), rs2 (divisor)
//   out_valid/out_ready: response handshake; result
//   busy               : unit is not idle
// master = requester (EX stage), slave = divide unit.
interface div_sequencer_if;
    import div_sequencer_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/div_sequencer_sub.sv
// Shared subtractor for the divide sequencer.
//   a_msb, a : minuend, XLEN+1 bits (a_msb is the bit shifted out of rem)
//   b        : subtrahend, XLEN bits
//   diff     : low XLEN bits of the difference
//   borrow   : set when {a_msb,a} < b (unsigned extended compare)
module div_sequencer_sub
    import div_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic            a_msb,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] diff,
    output logic            borrow
);

    // Two guard bits: the minuend is already XLEN+1 wide, the top bit flags the borrow.
    logic [XLEN+1:0] ext;

    assign ext    = {1'b0, a_msb, a} - {2'b00, b};
    assign diff   = ext[XLEN-1:0];
    assign borrow = ext[XLEN+1];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring division).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : div_sequencer_if.slave (flush, request and response handshakes, busy)
// One subtractor serves both the trial subtraction in CALC and the two
// sign negations (0 - x) in FIX, which is why FIX spans two cycles.
// Optional macro DIV_EARLY_OUT_EN: skip CALC when rs2 == 0 or |rs1| < |rs2|.
module div_sequencer
    import div_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             fix_ph_q, fix_ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             signed_op, accept;
    logic [XLEN-1:0]  abs1, abs2;
    logic [XLEN-1:0]  sub_a, sub_b, sub_diff;
    logic             sub_msb, sub_borrow;
    logic [XLEN-1:0]  rem_fix, quo_fix;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;

    // Request decode: op[0] set means unsigned.
    always_comb begin
        signed_op = ~bus.op[0];
        abs1      = (signed_op && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
        abs2      = (signed_op && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
        accept    = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
    end

    // Subtractor operand select: trial subtract in CALC, negate quo then rem in FIX.
    always_comb begin
        sub_a   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        sub_msb = rem_q[XLEN-1];
        sub_b   = dvsr_q;
        if (state_q == S_FIX) begin
            sub_a   = '0;
            sub_msb = 1'b0;
            sub_b   = fix_ph_q ? rem_q : quo_q;
        end
    end

    div_sequencer_sub u_sub (
        .a      (sub_a),
        .a_msb  (sub_msb),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // Divide by zero yields |rs1| in rem naturally, so only the quotient is forced.
    assign rem_fix = neg_rem_q ? sub_diff : rem_q;
    assign quo_fix = div0_q ? '1 : quo_q;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        fix_ph_d  = fix_ph_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = bus.op;
                    neg_quo_d = signed_op && (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                    neg_rem_d = signed_op && bus.rs1[XLEN-1];
                    div0_d    = (bus.rs2 == '0);
                    rem_d     = '0;
                    quo_d     = abs1;
                    dvsr_d    = abs2;
                    cnt_d     = CNT_W'(XLEN - 1);
                    fix_ph_d  = 1'b0;
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (bus.rs2 == '0 || abs1 < abs2) begin
                        quo_d   = '0;
                        rem_d   = abs1;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                // On borrow the shifted rem is below the divisor, so its top bit is zero.
                quo_d = {quo_q[XLEN-2:0], ~sub_borrow};
                rem_d = sub_borrow ? sub_a : sub_diff;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!fix_ph_q) begin
                    if (neg_quo_q) begin
                        quo_d = sub_diff;
                    end
                    fix_ph_d = 1'b1;
                end else begin
                    rem_d    = rem_fix;
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    fix_ph_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d  = S_IDLE;
            fix_ph_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            fix_ph_q  <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            fix_ph_q  <= fix_ph_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vectors plus a corner-operand sweep
// against a behavioural RV32M divide model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_sequencer_if bus ();

    div_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RV32M reference.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return op[1] ? r : q;
    endfunction

    // Issue one request, wait (bounded) for the result, then take it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit tmo);
        @(negedge clk);
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 100);
        tmo = !bus.out_valid;
        res = bus.result;
        if (!tmo) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    endtask

    task automatic test_unsigned();
        logic [31:0] r;
        int lat;
        bit tmo;
        int exp_lat;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat, tmo);
        checks++; if (tmo || r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", r, 32'd14); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
        run_op(OP_REMU, 32'd100, 32'd7, r, lat, tmo);
        checks++; if (tmo || r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", r, 32'd2); end
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 2;
`else
        exp_lat = 34;
`endif
        run_op(OP_DIVU, 32'd3, 32'd7, r, lat, tmo);
        checks++; if (tmo || r !== 32'd0) begin errors++; $display("FAIL divu_3_7 got %h want 0", r); end
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL small_latency got %0d want %0d", lat, exp_lat); end
    endtask

    // Directed signed, divide-by-zero and overflow vectors.
    task automatic test_special();
        logic [1:0]  ops [10] = '{OP_DIV, OP_REM, OP_REM, OP_DIV,
                                  OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                                  32'h8000_0000, 32'hFFFF_FFFB, 32'd5, 32'd5,
                                  32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [10] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                  32'd0, 32'd0, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd3,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0};
        logic [31:0] r;
        int lat;
        bit tmo;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], r, lat, tmo);
            checks++;
            if (tmo || r !== ex[i]) begin
                errors++;
                $display("FAIL special_%0d op=%0d %h/%h got %h want %h", i, ops[i], as[i], bs[i], r, ex[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat;
        bit tmo;
        bit seen;
        @(negedge clk);
        bus.op = OP_DIVU; bus.rs1 = 32'd50; bus.rs2 = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_out_valid got 1 want 0"); end
        // A request coinciding with flush must be dropped.
        bus.op = OP_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_accept busy got %b want 0", bus.busy); end
        run_op(OP_DIVU, 32'd9, 32'd3, r, lat, tmo);
        checks++; if (tmo || r !== 32'd3) begin errors++; $display("FAIL after_flush got %h want 3", r); end
    endtask

    task automatic test_hold_and_ignore();
        logic [31:0] r;
        int n;
        bit bad;
        @(negedge clk);
        bus.op = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Keep requesting with different operands while busy.
        bus.rs1 = 32'd5; bus.rs2 = 32'd1; bus.op = OP_REMU;
        repeat (20) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_flags in_ready=%b busy=%b want 0 1", bus.in_ready, bus.busy); end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        r = bus.result;
        checks++; if (bus.out_valid !== 1'b1 || r !== 32'd14) begin errors++; $display("FAIL ignore_busy got %h want %h", r, 32'd14); end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== r || bus.in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL done_hold result=%h out_valid=%b in_ready=%b want %h 1 0", bus.result, bus.out_valid, bus.in_ready, r); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL done_release in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.op = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid in_ready=%b out_valid=%b busy=%b result=%h want 1 0 0 0", bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
    endtask

    // Every op over a cross product of corner operands.
    task automatic test_corners();
        logic [31:0] vals [7] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'd100, 32'hFFFF_FFF9};
        logic [31:0] r, e;
        int lat;
        bit tmo;
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < 7; j++) begin
                    run_op(2'(o), vals[i], vals[j], r, lat, tmo);
                    e = ref_model(2'(o), vals[i], vals[j]);
                    checks++;
                    if (tmo || r !== e) begin
                        errors++;
                        $display("FAIL corner op=%0d %h/%h got %h want %h", o, vals[i], vals[j], r, e);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 2'b00; bus.rs1 = '0; bus.rs2 = '0;
        rst = 1'b1;
        test_reset();
        test_unsigned();
        test_special();
        test_flush();
        test_hold_and_ignore();
        test_rst_mid();
        test_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
